// File: rtl/fetch_queue.sv
// Circular instruction buffer between fetch and dispatch: in-order, N_WAY lanes per cycle, flushed on branch hazard.
// Optional conditional-branch predecode on the dispatch lanes is enabled by defining FETCH_QUEUE_PREDECODE_EN.
`ifndef N_WAY
`define N_WAY 2
`endif
`ifndef XLEN
`define XLEN 32
`endif

module fetch_queue #(
  parameter int DEPTH = 8
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [`N_WAY-1:0]                 fetch_valid,
  input  logic [`N_WAY-1:0][31:0]           fetch_inst,
  input  logic [`N_WAY-1:0][`XLEN-1:0]      fetch_pc,
  output logic                              fetch_ready,
  input  logic [`N_WAY-1:0]                 dispatched,
  input  logic                              branch_haz,
  output logic [`N_WAY-1:0]                 dispatch_valid,
  output logic [`N_WAY-1:0][31:0]           dispatch_inst,
  output logic [`N_WAY-1:0][`XLEN-1:0]      dispatch_pc,
  output logic [`N_WAY-1:0][`XLEN-1:0]      dispatch_npc,
  output logic [`N_WAY-1:0]                 branch_inst,
  output logic [$clog2(DEPTH):0]            count
);

  localparam int NW = `N_WAY;
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]          head, tail;
  logic [PW-1:0]          n_in, n_out;
  logic                   run_in, run_out;
  logic [31:0]            mem_inst [DEPTH];
  logic [`XLEN-1:0]       mem_pc   [DEPTH];
  logic [NW-1:0][AW-1:0]  rd_idx, wr_idx;

  // The wrap bit makes tail - head distinguish full from empty.
  assign count       = tail - head;
  assign fetch_ready = (PW'(DEPTH) - count) >= PW'(NW);

  always_comb begin
    n_in    = '0;
    n_out   = '0;
    run_in  = 1'b1;
    run_out = 1'b1;
    for (int k = 0; k < NW; k++) begin
      if (run_in && fetch_valid[k]) n_in = n_in + 1'b1;
      else                          run_in = 1'b0;
      if (run_out && dispatched[k] && dispatch_valid[k]) n_out = n_out + 1'b1;
      else                                               run_out = 1'b0;
    end
  end

  always_comb begin
    rd_idx         = '0;
    wr_idx         = '0;
    dispatch_valid = '0;
    dispatch_inst  = '0;
    dispatch_pc    = '0;
    dispatch_npc   = '0;
    for (int i = 0; i < NW; i++) begin
      rd_idx[i]         = AW'(head + PW'(i));
      wr_idx[i]         = AW'(tail + PW'(i));
      dispatch_valid[i] = (count > PW'(i)) && !branch_haz;
      if (dispatch_valid[i]) begin
        dispatch_inst[i] = mem_inst[rd_idx[i]];
        dispatch_pc[i]   = mem_pc[rd_idx[i]];
        dispatch_npc[i]  = mem_pc[rd_idx[i]] + `XLEN'(4);
      end
    end
  end

`ifdef FETCH_QUEUE_PREDECODE_EN
  always_comb begin
    branch_inst = '0;
    for (int i = 0; i < NW; i++)
      branch_inst[i] = dispatch_valid[i] && (dispatch_inst[i][6:0] == 7'b1100011);
  end
`else
  assign branch_inst = '0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      for (int d = 0; d < DEPTH; d++) begin
        mem_inst[d] <= '0;
        mem_pc[d]   <= '0;
      end
    end else if (branch_haz) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (fetch_ready) begin
        for (int k = 0; k < NW; k++) begin
          if (PW'(k) < n_in) begin
            mem_inst[wr_idx[k]] <= fetch_inst[k];
            mem_pc[wr_idx[k]]   <= fetch_pc[k];
          end
        end
        tail <= tail + n_in;
      end
      head <= head + n_out;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: a queue-based reference model predicts each cycle's dispatch view,
// a separate monitor pops and compares. Directed scenarios first, then randomized traffic.
`ifndef N_WAY
`define N_WAY 2
`endif
`ifndef XLEN
`define XLEN 32
`endif

module tb_fetch_queue;
  localparam int DEPTH = 8;
`ifdef FETCH_QUEUE_PREDECODE_EN
  localparam bit PRE = 1'b1;
`else
  localparam bit PRE = 1'b0;
`endif

  logic                         clock = 1'b0;
  logic                         reset = 1'b1;
  logic [1:0]                   fetch_valid = '0;
  logic [1:0][31:0]             fetch_inst = '0;
  logic [1:0][`XLEN-1:0]        fetch_pc = '0;
  logic                         fetch_ready;
  logic [1:0]                   dispatched = '0;
  logic                         branch_haz = 1'b0;
  logic [1:0]                   dispatch_valid;
  logic [1:0][31:0]             dispatch_inst;
  logic [1:0][`XLEN-1:0]        dispatch_pc;
  logic [1:0][`XLEN-1:0]        dispatch_npc;
  logic [1:0]                   branch_inst;
  logic [3:0]                   count;

  always #5 clock = ~clock;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .fetch_valid(fetch_valid), .fetch_inst(fetch_inst), .fetch_pc(fetch_pc),
    .fetch_ready(fetch_ready), .dispatched(dispatched), .branch_haz(branch_haz),
    .dispatch_valid(dispatch_valid), .dispatch_inst(dispatch_inst),
    .dispatch_pc(dispatch_pc), .dispatch_npc(dispatch_npc),
    .branch_inst(branch_inst), .count(count)
  );

  typedef struct packed {
    logic [31:0]      inst;
    logic [`XLEN-1:0] pc;
  } ent_t;

  typedef struct packed {
    logic [3:0]             cnt;
    logic                   rdy;
    logic [1:0]             vld;
    logic [1:0]             brn;
    logic [1:0][31:0]       inst;
    logic [1:0][`XLEN-1:0]  pc;
  } exp_t;

  ent_t mdl[$];
  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   acc;
  logic [`XLEN-1:0] pc;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic is_br(input logic [31:0] w);
    return w[6:0] == 7'b1100011;
  endfunction

  function automatic logic [31:0] rinst();
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(0, 2) == 0) w[6:0] = 7'b1100011;
    return w;
  endfunction

  // One cycle of stimulus: drive at negedge, predict this cycle's outputs, then advance the model.
  task automatic step(input logic [1:0] fv, input logic [1:0] dp, input logic hz,
                      input logic [31:0] i0, input logic [31:0] i1,
                      input logic [`XLEN-1:0] p0, output int accepted);
    exp_t e;
    int   cur, nout, nin;
    ent_t ne;
    @(negedge clock);
    fetch_valid   = fv;
    dispatched    = dp;
    branch_haz    = hz;
    fetch_inst[0] = i0;
    fetch_inst[1] = i1;
    fetch_pc[0]   = p0;
    fetch_pc[1]   = p0 + `XLEN'(4);
    cur   = mdl.size();
    e     = '0;
    e.cnt = 4'(cur);
    e.rdy = (DEPTH - cur) >= 2;
    for (int i = 0; i < 2; i++) begin
      if (i < cur && !hz) begin
        e.vld[i]  = 1'b1;
        e.inst[i] = mdl[i].inst;
        e.pc[i]   = mdl[i].pc;
        e.brn[i]  = PRE && is_br(mdl[i].inst);
      end
    end
    sb.push_back(e);
    accepted = 0;
    if (hz) begin
      mdl.delete();
    end else begin
      nout = 0;
      for (int i = 0; i < 2; i++)
        if (dp[i] && e.vld[i] && nout == i) nout++;
      for (int n = 0; n < nout; n++) mdl.delete(0);
      if (e.rdy) begin
        nin = 0;
        for (int i = 0; i < 2; i++)
          if (fv[i] && nin == i) nin++;
        for (int i = 0; i < nin; i++) begin
          ne.inst = (i == 0) ? i0 : i1;
          ne.pc   = p0 + `XLEN'(4 * i);
          mdl.push_back(ne);
        end
        accepted = nin;
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clock);
      #1;
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        chk("count", 64'(count), 64'(mon_e.cnt));
        chk("fetch_ready", 64'(fetch_ready), 64'(mon_e.rdy));
        chk("dispatch_valid", 64'(dispatch_valid), 64'(mon_e.vld));
        chk("branch_inst", 64'(branch_inst), 64'(mon_e.brn));
        for (int i = 0; i < 2; i++) begin
          chk($sformatf("inst%0d", i), 64'(dispatch_inst[i]), 64'(mon_e.inst[i]));
          chk($sformatf("pc%0d", i), 64'(dispatch_pc[i]), 64'(mon_e.pc[i]));
          chk($sformatf("npc%0d", i), 64'(dispatch_npc[i]),
              mon_e.vld[i] ? 64'(`XLEN'(mon_e.pc[i] + `XLEN'(4))) : 64'(0));
        end
      end
    end
  end

  initial begin
    pc = '0;
    #2;
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_ready", 64'(fetch_ready), 64'(1));
    chk("rst_valid", 64'(dispatch_valid), 64'(0));
    chk("rst_branch", 64'(branch_inst), 64'(0));
    chk("rst_inst", 64'(dispatch_inst), 64'(0));
    #5 reset = 1'b0;

    // Fill to full; fifth bundle must be dropped.
    repeat (5) begin
      step(2'b11, 2'b00, 1'b0, rinst(), rinst(), pc, acc);
      pc = pc + `XLEN'(4 * acc);
    end
    #2;
    chk("fill_count", 64'(count), 64'(8));
    chk("fill_ready", 64'(fetch_ready), 64'(0));
    step(2'b00, 2'b00, 1'b0, 32'h0, 32'h0, pc, acc);
    #2;
    chk("fill_dropped_count", 64'(count), 64'(8));
    chk("fill_lane0_pc", 64'(dispatch_pc[0]), 64'(0));
    chk("fill_lane1_pc", 64'(dispatch_pc[1]), 64'(4));

    // Steady dispatch-2/fetch-2 across the index rollover.
    repeat (6) begin
      step(2'b11, 2'b11, 1'b0, rinst(), rinst(), pc, acc);
      pc = pc + `XLEN'(4 * acc);
    end
    #2;
    chk("wrap_count", 64'(count), 64'(6));
    while (mdl.size() > 0) step(2'b00, 2'b11, 1'b0, 32'h0, 32'h0, pc, acc);

    // Partial masks.
    step(2'b10, 2'b00, 1'b0, rinst(), rinst(), pc, acc);
    step(2'b00, 2'b00, 1'b0, 32'h0, 32'h0, pc, acc);
    #2;
    chk("partial_fetch_count", 64'(count), 64'(0));
    step(2'b11, 2'b00, 1'b0, rinst(), rinst(), pc, acc);
    pc = pc + `XLEN'(4 * acc);
    step(2'b00, 2'b10, 1'b0, 32'h0, 32'h0, pc, acc);
    step(2'b00, 2'b00, 1'b0, 32'h0, 32'h0, pc, acc);
    #2;
    chk("partial_dispatch_count", 64'(count), 64'(2));

    // Flush at count 5 with simultaneous fetch and dispatch.
    step(2'b11, 2'b00, 1'b0, rinst(), rinst(), pc, acc);
    pc = pc + `XLEN'(4 * acc);
    step(2'b01, 2'b00, 1'b0, rinst(), rinst(), pc, acc);
    pc = pc + `XLEN'(4 * acc);
    step(2'b11, 2'b11, 1'b1, rinst(), rinst(), pc, acc);
    #2;
    chk("flush_valid", 64'(dispatch_valid), 64'(0));
    step(2'b00, 2'b00, 1'b0, 32'h0, 32'h0, pc, acc);
    #2;
    chk("flush_count", 64'(count), 64'(0));
    chk("flush_ready", 64'(fetch_ready), 64'(1));

    // Asynchronous reset between edges at count 4.
    step(2'b11, 2'b00, 1'b0, rinst(), rinst(), pc, acc);
    pc = pc + `XLEN'(4 * acc);
    step(2'b11, 2'b00, 1'b0, rinst(), rinst(), pc, acc);
    pc = pc + `XLEN'(4 * acc);
    step(2'b00, 2'b00, 1'b0, 32'h0, 32'h0, pc, acc);
    #3 reset = 1'b1;
    #1;
    chk("areset_count", 64'(count), 64'(0));
    chk("areset_valid", 64'(dispatch_valid), 64'(0));
    reset = 1'b0;
    mdl.delete();

    // Predecode: beq in lane 0, add in lane 1.
    step(2'b11, 2'b00, 1'b0, 32'h00208463, 32'h002081b3, pc, acc);
    pc = pc + `XLEN'(4 * acc);
    step(2'b00, 2'b00, 1'b0, 32'h0, 32'h0, pc, acc);
    #2;
    chk("predecode", 64'(branch_inst), PRE ? 64'(2'b01) : 64'(2'b00));
    while (mdl.size() > 0) step(2'b00, 2'b11, 1'b0, 32'h0, 32'h0, pc, acc);

    // Randomized traffic.
    repeat (400) begin
      step(2'($urandom), 2'($urandom), ($urandom_range(0, 19) == 0), rinst(), rinst(), pc, acc);
      pc = pc + `XLEN'(4 * acc);
    end
    step(2'b00, 2'b00, 1'b0, 32'h0, 32'h0, pc, acc);
    @(negedge clock);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Circular instruction buffer between the fetch unit and the R10K dispatch stage. Accepts bundles of up to `N_WAY` instructions per cycle from fetch and presents the oldest `N_WAY` buffered instructions, in program order, to dispatch. Dispatch consumes an in-order prefix each cycle. A branch hazard flushes the whole queue. Optional predecode flags conditional branches for dispatch.

## Interface
- `DEPTH`, default 8: number of entries. Power of two, at least 2×`N_WAY`.
- `N_WAY` and `XLEN`: taken from the global macros, not parameters.
- `clock`  in  1  sole clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `fetch_valid`  in  `N_WAY`  lanes offered by fetch; only the contiguous prefix from lane 0 counts.
- `fetch_inst`  in  `N_WAY`×32  instruction words.
- `fetch_pc`  in  `N_WAY`×`XLEN`  PC of each lane.
- `fetch_ready`  out  1  queue can accept a full `N_WAY` bundle this cycle.
- `dispatched`  in  `N_WAY`  lanes consumed by dispatch this cycle; a contiguous prefix.
- `branch_haz`  in  1  mispredict flush.
- `dispatch_valid`  out  `N_WAY`  lane i holds a valid instruction.
- `dispatch_inst`  out  `N_WAY`×32  oldest instructions; lane 0 is the oldest.
- `dispatch_pc`, `dispatch_npc`  out  `N_WAY`×`XLEN`  PC, and PC+4.
- `branch_inst`  out  `N_WAY`  lane holds a conditional branch (opcode 7'b1100011).
- `count`  out  $clog2(`DEPTH`)+1  occupied entries.

## Operation
- Storage: `DEPTH` entries of {inst, pc}.
- Pointers `head` and `tail` are $clog2(`DEPTH`)+1 bits wide. The low bits index storage; the MSB is a wrap bit.
- `count` = `tail` − `head`, modulo 2^($clog2(`DEPTH`)+1).
  - Full when `count` == `DEPTH`; empty when `count` == 0.
- `fetch_ready` = (`DEPTH` − `count` ≥ `N_WAY`).
  - It depends only on registered `count`; there is no combinational path from `dispatched`.
- Enqueue (when `fetch_ready` && !`branch_haz`):
  - n_in = length of the leading run of 1s in `fetch_valid`.
  - Lane k writes entry (`tail`+k) for k < n_in; then `tail` += n_in.
  - Lanes after the first 0 are dropped.
  - When `fetch_ready` = 0, the whole bundle is dropped; fetch must hold it and retry.
- Dequeue (when !`branch_haz`):
  - mask = `dispatched` & `dispatch_valid`.
  - n_out = length of the leading run of 1s in mask; then `head` += n_out.
  - Bits after the first 0 are ignored.
- Output lane i (combinational from registered state):
  - `dispatch_valid`[i] = (i < `count`) && !`branch_haz`.
  - `dispatch_inst`/`dispatch_pc` read entry (`head`+i); `dispatch_npc` = pc + 4, truncated to `XLEN`.
  - Invalid lanes drive 0 on inst, pc, npc and `branch_inst`.
- Flush: `branch_haz` high at a posedge sets `head` = `tail` = 0. Enqueue and dequeue in that cycle are discarded.
- Enqueue and dequeue in the same cycle are applied together: `count` += n_in − n_out.

## Timing
- Reset value of every output is 0, except `fetch_ready`, which is 1. Entry contents are cleared to 0.
- Reset takes effect asynchronously, without waiting for a clock edge.
- Latency: a bundle enqueued at edge t is visible on `dispatch_*` after edge t, i.e. one cycle minimum. There is no fetch-to-dispatch bypass.
- Dequeue is effective at the posedge where `dispatched` is sampled. The next-oldest entries appear in lane 0 after that edge.
- During the `branch_haz` cycle, `dispatch_valid` = 0 combinationally. After the edge the queue is empty, and `fetch_ready` = 1.
- Wrap-around: pointer low bits roll from `DEPTH`−1 to 0 with the wrap bit toggled. Bundle lanes may straddle the wrap.
- Reset asserted mid-bundle: the partial state is discarded and nothing is enqueued.

## Configuration
- `FETCH_QUEUE_PREDECODE_EN` defined:
  - `branch_inst`[i] = `dispatch_valid`[i] && `dispatch_inst`[i][6:0] == 7'b1100011.
  - The decode is combinational on the output lanes.
- Not defined: `branch_inst` is tied to 0, and dispatch performs its own branch identification.

## Test plan
Benches use `N_WAY`=2, `DEPTH`=8.
- Fill to full:
  - Stimulus: `fetch_valid`=2'b11 for 5 cycles with `dispatched`=0, PCs 0,4,…
  - Response: `count` reaches 8 after the 4th edge; `fetch_ready`=0 on cycle 5; the 5th bundle is dropped; lane 0 pc=0, lane 1 pc=4.
- Wrap-around:
  - Stimulus: fill 8 entries, then dispatch 2 and fetch 2 every cycle for 6 cycles.
  - Response: `count` stays 6 at each edge; pcs leave strictly in order 0,4,8,…; no entry is duplicated or lost across the index 7→0 rollover.
- Partial masks:
  - Stimulus: `fetch_valid`=2'b10 at `count`=0.
  - Response: nothing enqueued, `count`=0.
  - Stimulus: at `count`=2, `dispatched`=2'b10.
  - Response: nothing dequeued.
- Flush:
  - Stimulus: at `count`=5, assert `branch_haz` together with `fetch_valid`=2'b11 and `dispatched`=2'b11.
  - Response: `dispatch_valid`=0 in that cycle; after the edge `count`=0 and `fetch_ready`=1.
- Asynchronous reset:
  - Stimulus: at `count`=4, pulse `reset` between edges.
  - Response: `count`=0 and `dispatch_valid`=0 before the next posedge.
- Predecode (macro on):
  - Stimulus: lane 0 = 0x00208463 (beq x1,x2,8), lane 1 = 0x002081b3 (add x3,x1,x2).
  - Response: `branch_inst`=2'b01.
  - Macro off: `branch_inst`=2'b00.
